write_resp_channel_arb: RTL and testbench
=========================================

// Module: write_resp_channel_arb
// PURPOSE
//  Slave-side counterpart of the write-response decoder. Arbitrates B-channel
//  responses from two slaves (M00/M01) and captures the winner into registers.
//  Presents it as Sel_Resp_ID/Sel_Write_Resp/Sel_Valid to the decoder, which routes it to masters S00/S01.
//  Completes the handshake using the bready of the master addressed by the held ID.
// PARAMETERS
//  Num_Of_Masters   2                        number of masters (fixed at 2 in this block)
//  Master_ID_Width  $clog2(Num_Of_Masters)   width of BID / Sel_Resp_ID
//  M1_ID            'd0                      ID routed to master S00
//  M2_ID            'd1                      ID routed to master S01
// PORTS
//  ACLK            in   1   clock, all logic on rising edge
//  ARESETN         in   1   reset, synchronous, active-low
//  M00_AXI_bid     in   Master_ID_Width  slave 0 response ID
//  M00_AXI_bresp   in   2   slave 0 write response
//  M00_AXI_bvalid  in   1   slave 0 response valid
//  M00_AXI_bready  out  1   accept strobe to slave 0
//  M01_AXI_bid     in   Master_ID_Width  slave 1 response ID
//  M01_AXI_bresp   in   2   slave 1 write response
//  M01_AXI_bvalid  in   1   slave 1 response valid
//  M01_AXI_bready  out  1   accept strobe to slave 1
//  S00_AXI_bready  in   1   master S00 ready for response
//  S01_AXI_bready  in   1   master S01 ready for response
//  Sel_Resp_ID     out  Master_ID_Width  held response ID (registered)
//  Sel_Write_Resp  out  2   held response code (registered)
//  Sel_Valid       out  1   held response valid (registered)
//  Drop_Err        out  1   1-cycle pulse: held ID matched no master, response dropped
// BEHAVIOUR
//  Reset (ARESETN=0 at edge): state=IDLE, Sel_Valid=0, Sel_Resp_ID=0, Sel_Write_Resp=0,
//   Drop_Err=0, last_grant=1 (slave 0 wins first); any held response is discarded.
//  FSM states: IDLE, HOLD.
//  IDLE: grant = round-robin over {M00,M01} bvalid; if both valid, the slave != last_grant wins.
//   M0x_AXI_bready = (state==IDLE) & grant==x & M0x_AXI_bvalid (combinational, never both high).
//   On accepting edge: capture winner bid/bresp -> Sel_*, Sel_Valid<=1, last_grant<=x, ->HOLD.
//   No bvalid: stay IDLE, both bready=0.
//  HOLD: all M0x bready=0. route_ready = S00_AXI_bready if Sel_Resp_ID==M1_ID,
//   S01_AXI_bready if ==M2_ID, else 1 (unmapped ID).
//   Sel_Valid & route_ready at edge -> Sel_Valid<=0, ->IDLE; Sel_* remain stable until then.
//   Unmapped ID: leave after exactly 1 HOLD cycle, Drop_Err=1 on the cycle after (registered pulse).
//  Latency: bvalid seen in cycle N -> bready high in N -> Sel_Valid high in N+1.
//   Min 2 cycles per response (one IDLE bubble); no back-to-back grant.
//  Sel_Write_Resp passes bresp unmodified (OKAY/EXOKAY/SLVERR/DECERR), 2 bits.
//  Slave dropping bvalid while not granted: no effect; arbiter never drops an accepted response.
//  Reset asserted in HOLD: response lost, Sel_Valid=0 the next cycle, no Drop_Err.
// TESTING
//  1 Reset: ARESETN=0 two cycles with both bvalid=1 -> both bready=0, Sel_Valid=0, Sel_*=0.
//  2 Single: M00 bvalid, bid=1, bresp=2'b10 -> M00 bready same cycle; next cycle Sel_Valid=1,
//    Sel_Resp_ID=1, Sel_Write_Resp=2'b10; S01_AXI_bready=0 for 3 cycles -> held stable;
//    S01_AXI_bready=1 -> Sel_Valid=0 next cycle.
//  3 Contention: both bvalid=1 continuously, masters always ready -> grants M00,M01,M00,M01,
//    one accept every 2 cycles, each Sel_Resp_ID/Sel_Write_Resp matching its source slave.
//  4 Wrong-master ready: held ID=M1_ID, S01_AXI_bready=1, S00_AXI_bready=0 -> Sel_Valid stays 1.
//  5 Unmapped ID: Master_ID_Width=2, bid=3 -> Sel_Valid 1 cycle, then Sel_Valid=0 and Drop_Err=1 pulse.
//  6 Reset in HOLD: ARESETN=0 while Sel_Valid=1 -> Sel_Valid=0 next cycle, IDLE, slave 0 wins next.

Source files
------------

// File: rtl/write_resp_channel_arb.sv
`default_nettype none
// ============================================================================
//  Module      : write_resp_channel_arb
//  Description : Write-response (B channel) arbiter. Picks one of two slave
//                responses (M00/M01) round-robin, captures it into holding
//                registers and presents it as Sel_Resp_ID/Sel_Write_Resp/
//                Sel_Valid. The held response is released when the master
//                addressed by its ID asserts bready. A held ID that maps to
//                no master is released after one cycle and reported through
//                a one-cycle Drop_Err pulse.
//  Ports       : ACLK, ARESETN (sync, active-low)
//                M00_AXI_b{id,resp,valid} in / M00_AXI_bready out
//                M01_AXI_b{id,resp,valid} in / M01_AXI_bready out
//                S00_AXI_bready, S01_AXI_bready in (master readiness)
//                Sel_Resp_ID, Sel_Write_Resp, Sel_Valid out (registered)
//                Drop_Err out (registered one-cycle pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
module write_resp_channel_arb #(
  parameter int Num_Of_Masters  = 2,
  parameter int Master_ID_Width = $clog2(Num_Of_Masters),
  parameter logic [Master_ID_Width-1:0] M1_ID = 'd0,
  parameter logic [Master_ID_Width-1:0] M2_ID = 'd1
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic [Master_ID_Width-1:0] M00_AXI_bid,
  input  logic [1:0]                 M00_AXI_bresp,
  input  logic                       M00_AXI_bvalid,
  output logic                       M00_AXI_bready,
  input  logic [Master_ID_Width-1:0] M01_AXI_bid,
  input  logic [1:0]                 M01_AXI_bresp,
  input  logic                       M01_AXI_bvalid,
  output logic                       M01_AXI_bready,
  input  logic                       S00_AXI_bready,
  input  logic                       S01_AXI_bready,
  output logic [Master_ID_Width-1:0] Sel_Resp_ID,
  output logic [1:0]                 Sel_Write_Resp,
  output logic                       Sel_Valid,
  output logic                       Drop_Err
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state;
  logic   last_grant;   // slave granted most recently (0 = M00, 1 = M01)
  logic   grant;        // slave selected this cycle while idle
  logic   id_mapped;
  logic   route_ready;

  // Round-robin: on contention the slave that did not win last time wins.
  // With a single requester that requester is selected; with none, the
  // value is irrelevant because both bready terms are masked by bvalid.
  always_comb begin
    if (M00_AXI_bvalid && M01_AXI_bvalid) begin
      grant = ~last_grant;
    end else begin
      grant = M01_AXI_bvalid;
    end
  end

  // No handshake is offered while reset is asserted: anything accepted
  // then would be discarded by the reset anyway.
  assign M00_AXI_bready = ARESETN & (state == IDLE) & ~grant & M00_AXI_bvalid;
  assign M01_AXI_bready = ARESETN & (state == IDLE) &  grant & M01_AXI_bvalid;

  // Readiness of the master addressed by the held ID; an unmapped ID is
  // treated as always ready so the response is flushed after one cycle.
  always_comb begin
    id_mapped   = 1'b1;
    route_ready = 1'b1;
    if (Sel_Resp_ID == M1_ID) begin
      route_ready = S00_AXI_bready;
    end else if (Sel_Resp_ID == M2_ID) begin
      route_ready = S01_AXI_bready;
    end else begin
      id_mapped = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      Sel_Resp_ID    <= '0;
      Sel_Write_Resp <= 2'b00;
      Sel_Valid      <= 1'b0;
      Drop_Err       <= 1'b0;
    end else begin
      Drop_Err <= 1'b0;
      case (state)
        IDLE: begin
          if (M00_AXI_bready) begin
            Sel_Resp_ID    <= M00_AXI_bid;
            Sel_Write_Resp <= M00_AXI_bresp;
            Sel_Valid      <= 1'b1;
            last_grant     <= 1'b0;
            state          <= HOLD;
          end else if (M01_AXI_bready) begin
            Sel_Resp_ID    <= M01_AXI_bid;
            Sel_Write_Resp <= M01_AXI_bresp;
            Sel_Valid      <= 1'b1;
            last_grant     <= 1'b1;
            state          <= HOLD;
          end
        end
        HOLD: begin
          if (Sel_Valid && route_ready) begin
            Sel_Valid <= 1'b0;
            Drop_Err  <= ~id_mapped;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          Sel_Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_write_resp_channel_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_write_resp_channel_arb
//  Description : Self-checking bench for write_resp_channel_arb with a
//                two-bit ID so that unmapped IDs (2, 3) can be exercised.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_write_resp_channel_arb;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] b0id, b1id, b0resp, b1resp;
  logic       b0v, b1v, b0r, b1r, s0r, s1r;
  logic [1:0] sid, sresp;
  logic       sv, derr;

  int errors = 0;
  int checks = 0;

  // Reference model state: a response is either held or not.
  bit       m_hold;
  bit [1:0] m_id, m_resp;
  bit       m_last;   // slave that won most recently
  bit       m_drop;

  always #5 clk = ~clk;

  write_resp_channel_arb #(
    .Num_Of_Masters (2),
    .Master_ID_Width(2),
    .M1_ID          (2'd0),
    .M2_ID          (2'd1)
  ) dut (
    .ACLK          (clk),
    .ARESETN       (rstn),
    .M00_AXI_bid   (b0id),
    .M00_AXI_bresp (b0resp),
    .M00_AXI_bvalid(b0v),
    .M00_AXI_bready(b0r),
    .M01_AXI_bid   (b1id),
    .M01_AXI_bresp (b1resp),
    .M01_AXI_bvalid(b1v),
    .M01_AXI_bready(b1r),
    .S00_AXI_bready(s0r),
    .S01_AXI_bready(s1r),
    .Sel_Resp_ID   (sid),
    .Sel_Write_Resp(sresp),
    .Sel_Valid     (sv),
    .Drop_Err      (derr)
  );

  // Advance one clock; leave the bench 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b0v = 0; b1v = 0; b0id = 0; b1id = 0; b0resp = 0; b1resp = 0;
    s0r = 1; s1r = 1;
  endtask

  task automatic do_reset();
    rstn = 0;
    tick();
    rstn = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 0;
    b0v = 1; b1v = 1; b0id = 2'd1; b1id = 2'd0; b0resp = 2'b11; b1resp = 2'b01;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (b0r !== 1'b0 || b1r !== 1'b0) begin
        errors++; $display("FAIL reset_bready: got %b%b want 00", b0r, b1r);
      end
      checks++;
      if (sv !== 1'b0 || sid !== 2'd0 || sresp !== 2'd0 || derr !== 1'b0) begin
        errors++; $display("FAIL reset_regs: got v=%b id=%0d resp=%0d drop=%b want 0 0 0 0",
                           sv, sid, sresp, derr);
      end
    end
    idle_inputs();
    rstn = 1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    idle_inputs();
    b0v = 1; b0id = 2'd1; b0resp = 2'b10; s1r = 0; s0r = 1;
    #1;
    checks++;
    if (b0r !== 1'b1 || b1r !== 1'b0) begin
      errors++; $display("FAIL single_bready: got %b%b want 10", b0r, b1r);
    end
    tick();
    b0v = 0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (sv !== 1'b1 || sid !== 2'd1 || sresp !== 2'b10) begin
        errors++; $display("FAIL single_hold c%0d: got v=%b id=%0d resp=%0d want 1 1 2",
                           c, sv, sid, sresp);
      end
      tick();
    end
    s1r = 1;
    tick();
    checks++;
    if (sv !== 1'b0 || derr !== 1'b0) begin
      errors++; $display("FAIL single_release: got v=%b drop=%b want 0 0", sv, derr);
    end
  endtask

  task automatic test_contention();
    do_reset();
    idle_inputs();
    b0v = 1; b1v = 1; b0id = 2'd0; b0resp = 2'b01; b1id = 2'd1; b1resp = 2'b11;
    #1;
    for (int g = 0; g < 4; g++) begin
      bit w = g[0];   // expected winner: M00, M01, M00, M01
      checks++;
      if (b0r !== !w || b1r !== w) begin
        errors++; $display("FAIL contention_grant g%0d: got %b%b want %b%b", g, b0r, b1r, !w, w);
      end
      tick();
      checks++;
      if (sv !== 1'b1 || sid !== (w ? 2'd1 : 2'd0) || sresp !== (w ? 2'b11 : 2'b01)
          || b0r !== 1'b0 || b1r !== 1'b0) begin
        errors++; $display("FAIL contention_hold g%0d: got v=%b id=%0d resp=%0d rdy=%b%b",
                           g, sv, sid, sresp, b0r, b1r);
      end
      tick();
      checks++;
      if (sv !== 1'b0) begin
        errors++; $display("FAIL contention_release g%0d: got v=%b want 0", g, sv);
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrong_master();
    do_reset();
    idle_inputs();
    b1v = 1; b1id = 2'd0; b1resp = 2'b00; s0r = 0; s1r = 1;
    tick();
    b1v = 0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (sv !== 1'b1 || sid !== 2'd0) begin
        errors++; $display("FAIL wrong_master c%0d: got v=%b id=%0d want 1 0", c, sv, sid);
      end
      tick();
    end
    s0r = 1;
    tick();
    checks++;
    if (sv !== 1'b0) begin
      errors++; $display("FAIL wrong_master_release: got v=%b want 0", sv);
    end
  endtask

  task automatic test_unmapped();
    for (int k = 2; k < 4; k++) begin
      do_reset();
      idle_inputs();
      s0r = 0; s1r = 0;
      b1v = 1; b1id = 2'(k); b1resp = 2'b11;
      tick();
      b1v = 0;
      checks++;
      if (sv !== 1'b1 || sid !== 2'(k) || derr !== 1'b0) begin
        errors++; $display("FAIL unmapped_hold id%0d: got v=%b id=%0d drop=%b want 1 %0d 0",
                           k, sv, sid, derr, k);
      end
      tick();
      checks++;
      if (sv !== 1'b0 || derr !== 1'b1) begin
        errors++; $display("FAIL unmapped_drop id%0d: got v=%b drop=%b want 0 1", k, sv, derr);
      end
      tick();
      checks++;
      if (derr !== 1'b0) begin
        errors++; $display("FAIL unmapped_pulse id%0d: got drop=%b want 0", k, derr);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    idle_inputs();
    s0r = 0; s1r = 0;
    b0v = 1; b0id = 2'd1; b0resp = 2'b01;   // M00 wins, so M01 would be next
    tick();
    b0v = 0;
    checks++;
    if (sv !== 1'b1) begin
      errors++; $display("FAIL rst_hold_pre: got v=%b want 1", sv);
    end
    rstn = 0;
    tick();
    rstn = 1;
    checks++;
    if (sv !== 1'b0 || derr !== 1'b0 || sid !== 2'd0) begin
      errors++; $display("FAIL rst_hold_clear: got v=%b drop=%b id=%0d want 0 0 0", sv, derr, sid);
    end
    b0v = 1; b1v = 1; b1id = 2'd0;
    #1;
    checks++;
    if (b0r !== 1'b1 || b1r !== 1'b0) begin
      errors++; $display("FAIL rst_hold_rr: got %b%b want 10", b0r, b1r);
    end
    tick();
    checks++;
    if (derr !== 1'b0) begin
      errors++; $display("FAIL rst_hold_nodrop: got drop=%b want 0", derr);
    end
    idle_inputs();
    tick();
  endtask

  // Randomized traffic against a transaction-level model.
  task automatic test_random();
    bit e0, e1, rr;
    do_reset();
    idle_inputs();
    m_hold = 0; m_id = 0; m_resp = 0; m_last = 1; m_drop = 0;
    for (int c = 0; c < 400; c++) begin
      rstn   = ($urandom_range(0, 39) != 0);
      b0v    = $urandom_range(0, 1) == 1;
      b1v    = $urandom_range(0, 1) == 1;
      b0id   = 2'($urandom_range(0, 3));
      b1id   = 2'($urandom_range(0, 3));
      b0resp = 2'($urandom_range(0, 3));
      b1resp = 2'($urandom_range(0, 3));
      s0r    = $urandom_range(0, 2) == 0;
      s1r    = $urandom_range(0, 2) == 0;
      #1;
      e0 = 0; e1 = 0;
      if (rstn && !m_hold) begin
        if (b0v && b1v) begin
          if (m_last) e0 = 1; else e1 = 1;
        end else if (b0v) e0 = 1;
        else if (b1v) e1 = 1;
      end
      checks++;
      if (b0r !== e0 || b1r !== e1) begin
        errors++; $display("FAIL random_bready c%0d: got %b%b want %b%b", c, b0r, b1r, e0, e1);
      end
      // Model next-cycle contents.
      if (!rstn) begin
        m_hold = 0; m_id = 0; m_resp = 0; m_last = 1; m_drop = 0;
      end else if (m_hold) begin
        rr = (m_id == 0) ? s0r : (m_id == 1) ? s1r : 1'b1;
        m_drop = 0;
        if (rr) begin
          m_hold = 0;
          m_drop = (m_id > 1);
        end
      end else begin
        m_drop = 0;
        if (e0) begin
          m_hold = 1; m_id = b0id; m_resp = b0resp; m_last = 0;
        end else if (e1) begin
          m_hold = 1; m_id = b1id; m_resp = b1resp; m_last = 1;
        end
      end
      @(posedge clk);
      #1;
      checks++;
      if (sv !== m_hold || derr !== m_drop || (m_hold && (sid !== m_id || sresp !== m_resp))) begin
        errors++; $display("FAIL random_regs c%0d: got v=%b id=%0d resp=%0d drop=%b want %b %0d %0d %b",
                           c, sv, sid, sresp, derr, m_hold, m_id, m_resp, m_drop);
      end
    end
    rstn = 1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rstn = 0;
    test_reset();
    test_single();
    test_contention();
    test_wrong_master();
    test_unmapped();
    test_reset_in_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
